// File: rtl/disp_scheduler.sv
// disp_scheduler: round-robin selector for four signed byte sources, converting the
// chosen value to blanked, sign-aware BCD for a four-digit display.
module disp_scheduler #(
  parameter int unsigned DWELL = 50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] src_data,
  input  logic [3:0]  src_req,
  input  logic        btn,
  input  logic        auto_en,
  output logic [1:0]  sel,
  output logic [15:0] bin,
  output logic [3:0]  neg,
  output logic [3:0]  en,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARB  = 3'd1,
    CONV = 3'd2,
    PUB  = 3'd3,
    SHOW = 3'd4
  } state_t;

  localparam logic [25:0] DWELL_LAST = 26'(DWELL - 1);

  state_t      state, state_nxt;
  logic        btn_q;
  logic [25:0] dwell_cnt;
  logic [7:0]  lat_data;
  logic [1:0]  gnt;
  logic        refresh;
  logic [19:0] dd;
  logic [2:0]  conv_cnt;

  logic [7:0]  cur_data, gnt_data, mag;
  logic        btn_fall, dwell_exp, any_req;
  logic        adv_evt, ref_evt, take_ref, enter_arb;
  logic [1:0]  next_sel, arb_sel, rr_idx;
  logic [3:0]  dig_h, dig_t, dig_o;
  logic [3:0]  en_fmt, neg_fmt;

  assign cur_data  = src_data[{sel, 3'b000} +: 8];
  assign btn_fall  = btn_q & ~btn;
  assign dwell_exp = auto_en && (dwell_cnt == DWELL_LAST);
  assign any_req   = |src_req;
  assign busy      = (state == ARB) || (state == CONV) || (state == PUB);
  assign enter_arb = (state_nxt == ARB);

  // Scan from farthest to nearest so the nearest requester after sel wins.
  always_comb begin
    next_sel = sel;
    rr_idx   = sel;
    for (int k = 4; k >= 1; k--) begin
      rr_idx = sel + 2'(k);
      if (src_req[rr_idx]) next_sel = rr_idx;
    end
  end

  assign arb_sel  = refresh ? sel : next_sel;
  assign gnt_data = src_data[{arb_sel, 3'b000} +: 8];
  assign mag      = gnt_data[7] ? (~gnt_data + 8'd1) : gnt_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    adv_evt   = 1'b0;
    ref_evt   = 1'b0;
    take_ref  = 1'b0;
    case (state)
      IDLE: begin
        adv_evt = btn_fall | dwell_exp | any_req;
        if (adv_evt) state_nxt = ARB;
      end
      SHOW: begin
        adv_evt = btn_fall | dwell_exp | ~src_req[sel];
        ref_evt = (cur_data != lat_data);
        if (adv_evt || ref_evt) begin
          state_nxt = ARB;
          take_ref  = ~adv_evt;
        end
      end
      ARB:     state_nxt = (refresh || any_req) ? CONV : IDLE;
      CONV:    if (conv_cnt == 3'd7) state_nxt = PUB;
      PUB:     state_nxt = SHOW;
      default: state_nxt = IDLE;
    endcase
  end

  // One double-dabble iteration: BCD lives in [19:8], binary in [7:0].
  function automatic logic [19:0] dd_step(input logic [19:0] v);
    logic [19:0] a;
    a = v;
    for (int d = 0; d < 3; d++) begin
      if (a[8 + 4*d +: 4] >= 4'd5) a[8 + 4*d +: 4] = a[8 + 4*d +: 4] + 4'd3;
    end
    return {a[18:0], 1'b0};
  endfunction

  assign dig_h = dd[19:16];
  assign dig_t = dd[15:12];
  assign dig_o = dd[11:8];

  always_comb begin
    en_fmt  = 4'b0001;
    neg_fmt = 4'b0000;
    if (dig_h != 4'd0)      en_fmt = 4'b0111;
    else if (dig_t != 4'd0) en_fmt = 4'b0011;
    if (lat_data[7]) begin
      neg_fmt = en_fmt + 4'd1;
      en_fmt  = en_fmt | neg_fmt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q     <= 1'b1;
      dwell_cnt <= 26'd0;
      lat_data  <= 8'd0;
      gnt       <= 2'd0;
      refresh   <= 1'b0;
      dd        <= 20'd0;
      conv_cnt  <= 3'd0;
      sel       <= 2'd0;
      bin       <= 16'd0;
      neg       <= 4'd0;
      en        <= 4'd0;
    end else begin
      btn_q <= btn;
      if (enter_arb || !auto_en) dwell_cnt <= 26'd0;
      else if (state == SHOW)    dwell_cnt <= dwell_cnt + 26'd1;
      if (enter_arb) refresh <= take_ref;
      case (state)
        ARB: begin
          if (refresh || any_req) begin
            gnt      <= arb_sel;
            lat_data <= gnt_data;
            dd       <= {12'd0, mag};
            conv_cnt <= 3'd0;
          end else begin
            en  <= 4'd0;
            neg <= 4'd0;
          end
        end
        CONV: begin
          dd       <= dd_step(dd);
          conv_cnt <= conv_cnt + 3'd1;
        end
        PUB: begin
          sel <= gnt;
          bin <= {4'd0, dig_h, dig_t, dig_o};
          en  <= en_fmt;
          neg <= neg_fmt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_disp_scheduler.sv
// tb_disp_scheduler: scoreboard bench for disp_scheduler; expected displays are queued
// when a trigger is driven and compared when the block finishes publishing.
module tb_disp_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] src_data = 32'd0;
  logic [3:0]  src_req = 4'd0;
  logic        btn = 1'b1;
  logic        auto_en = 1'b0;
  logic [1:0]  sel;
  logic [15:0] bin;
  logic [3:0]  neg, en;
  logic        busy;

  disp_scheduler #(.DWELL(20)) dut (
    .clk(clk), .rst_n(rst_n), .src_data(src_data), .src_req(src_req), .btn(btn),
    .auto_en(auto_en), .sel(sel), .bin(bin), .neg(neg), .en(en), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] bin;
    logic [3:0]  en;
    logic [3:0]  neg;
    logic [15:0] mask;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  function automatic exp_t model(input logic [1:0] s, input logic [7:0] v);
    exp_t e;
    int m, h, t, o, nd;
    m  = v[7] ? 256 - int'(v) : int'(v);
    h  = m / 100;
    t  = (m / 10) % 10;
    o  = m % 10;
    nd = (h != 0) ? 3 : (t != 0) ? 2 : 1;
    e.sel  = s;
    e.bin  = {4'h0, 4'(h), 4'(t), 4'(o)};
    e.en   = 4'((1 << nd) - 1);
    e.neg  = 4'd0;
    e.mask = 16'd0;
    for (int k = 0; k < nd; k++) e.mask[4*k +: 4] = 4'hF;
    if (v[7]) begin
      e.neg = 4'(1 << nd);
      e.en  = e.en | e.neg;
    end
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Edges until busy rises and until it falls again; -1 when the bound expires.
  task automatic wait_pub(output int t_busy, output int t_done);
    t_busy = -1;
    t_done = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      btn = 1'b1;
      if (busy === 1'b1 && t_busy < 0) t_busy = k;
      if (t_busy >= 0 && busy === 1'b0) begin
        t_done = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({sel, bin, neg, en, busy} !== 27'd0)
      $display("FAIL reset_async: got sel=%0d bin=%h neg=%b en=%b busy=%b, want all 0", sel, bin, neg, en, busy);
    else passed++;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    total++;
    if ({sel, bin, neg, en, busy} !== 27'd0)
      $display("FAIL reset_idle: got sel=%0d bin=%h neg=%b en=%b busy=%b, want all 0", sel, bin, neg, en, busy);
    else passed++;
  endtask

  task automatic test_neg128;
    exp_t e;
    int tb, td;
    src_data[7:0] = 8'h80;
    src_req = 4'b0001;
    exp_q.push_back(model(2'd0, 8'h80));
    wait_pub(tb, td);
    e = exp_q.pop_front();
    total++;
    if ({sel, en, neg} !== {e.sel, e.en, e.neg} || ((bin ^ e.bin) & e.mask) !== 16'h0)
      $display("FAIL neg128: got sel=%0d en=%b neg=%b bin=%h, want sel=%0d en=%b neg=%b bin=%h", sel, en, neg, bin, e.sel, e.en, e.neg, e.bin);
    else passed++;
    total++;
    if (bin[11:0] !== 12'h128) $display("FAIL neg128_bin: got %h, want 128", bin[11:0]);
    else passed++;
    total++;
    if (tb !== 1 || td !== 11) $display("FAIL neg128_latency: got busy@%0d done@%0d, want 1 and 11", tb, td);
    else passed++;
  endtask

  task automatic test_btn_rr;
    exp_t e;
    int tb, td, nbusy;
    logic [1:0] sq[3] = '{2'd1, 2'd3, 2'd0};
    logic [7:0] vq[3] = '{8'hF9, 8'h63, 8'h05};
    src_data = {8'h63, 8'h00, 8'hF9, 8'h05};
    src_req  = 4'b1011;
    exp_q.push_back(model(2'd0, 8'h05));
    wait_pub(tb, td);
    e = exp_q.pop_front();
    total++;
    if ({sel, en, neg} !== {e.sel, e.en, e.neg} || ((bin ^ e.bin) & e.mask) !== 16'h0)
      $display("FAIL rr_refresh: got sel=%0d en=%b neg=%b bin=%h, want sel=%0d en=%b neg=%b bin=%h", sel, en, neg, bin, e.sel, e.en, e.neg, e.bin);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      btn = 1'b0;
      exp_q.push_back(model(sq[i], vq[i]));
      wait_pub(tb, td);
      e = exp_q.pop_front();
      total++;
      if ({sel, en, neg} !== {e.sel, e.en, e.neg} || ((bin ^ e.bin) & e.mask) !== 16'h0)
        $display("FAIL rr_press%0d: got sel=%0d en=%b neg=%b bin=%h, want sel=%0d en=%b neg=%b bin=%h", i, sel, en, neg, bin, e.sel, e.en, e.neg, e.bin);
      else passed++;
      total++;
      if (tb !== 1 || td !== 11) $display("FAIL rr_latency%0d: got busy@%0d done@%0d, want 1 and 11", i, tb, td);
      else passed++;
    end
    nbusy = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (busy !== 1'b0) nbusy++;
    end
    total++;
    if (nbusy !== 0 || sel !== 2'd0) $display("FAIL rr_single: got busy cycles=%0d sel=%0d, want 0 and 0", nbusy, sel);
    else passed++;
  endtask

  task automatic test_dwell;
    exp_t e;
    int tb, td;
    src_req = 4'b0110;
    auto_en = 1'b1;
    exp_q.push_back(model(2'd1, 8'hF9));
    wait_pub(tb, td);
    e = exp_q.pop_front();
    total++;
    if ({sel, en, neg} !== {e.sel, e.en, e.neg} || ((bin ^ e.bin) & e.mask) !== 16'h0)
      $display("FAIL dwell_start: got sel=%0d en=%b neg=%b bin=%h, want sel=%0d en=%b neg=%b bin=%h", sel, en, neg, bin, e.sel, e.en, e.neg, e.bin);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      if (i % 2 == 0) exp_q.push_back(model(2'd2, 8'h00));
      else            exp_q.push_back(model(2'd1, 8'hF9));
      wait_pub(tb, td);
      e = exp_q.pop_front();
      total++;
      if ({sel, en, neg} !== {e.sel, e.en, e.neg} || ((bin ^ e.bin) & e.mask) !== 16'h0)
        $display("FAIL dwell_adv%0d: got sel=%0d en=%b neg=%b bin=%h, want sel=%0d en=%b neg=%b bin=%h", i, sel, en, neg, bin, e.sel, e.en, e.neg, e.bin);
      else passed++;
      total++;
      if (tb !== 20 || td !== 30) $display("FAIL dwell_period%0d: got busy@%0d done@%0d, want 20 and 30", i, tb, td);
      else passed++;
    end
    tick(19);
    btn = 1'b0;
    exp_q.push_back(model(2'd1, 8'hF9));
    wait_pub(tb, td);
    e = exp_q.pop_front();
    auto_en = 1'b0;
    total++;
    if ({sel, en, neg} !== {e.sel, e.en, e.neg} || ((bin ^ e.bin) & e.mask) !== 16'h0)
      $display("FAIL dwell_coincide: got sel=%0d en=%b neg=%b bin=%h, want sel=%0d en=%b neg=%b bin=%h", sel, en, neg, bin, e.sel, e.en, e.neg, e.bin);
    else passed++;
    total++;
    if (tb !== 1 || td !== 11) $display("FAIL dwell_coincide_latency: got busy@%0d done@%0d, want 1 and 11", tb, td);
    else passed++;
  endtask

  task automatic test_refresh;
    exp_t e;
    int tb, td, nbusy;
    logic [7:0] vals[4] = '{8'h07, 8'h00, 8'h9C, 8'h05};
    src_data[23:16] = 8'h07;
    nbusy = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (busy !== 1'b0) nbusy++;
    end
    total++;
    if (nbusy !== 0) $display("FAIL refresh_other_src: got busy cycles=%0d, want 0", nbusy);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      src_data[23:16] = vals[i];
      if (i == 0 || i == 3) btn = 1'b0;
      if (i == 3) exp_q.push_back(model(2'd1, 8'hF9));
      else        exp_q.push_back(model(2'd2, vals[i]));
      wait_pub(tb, td);
      e = exp_q.pop_front();
      total++;
      if ({sel, en, neg} !== {e.sel, e.en, e.neg} || ((bin ^ e.bin) & e.mask) !== 16'h0)
        $display("FAIL refresh%0d: got sel=%0d en=%b neg=%b bin=%h, want sel=%0d en=%b neg=%b bin=%h", i, sel, en, neg, bin, e.sel, e.en, e.neg, e.bin);
      else passed++;
      total++;
      if (tb !== 1 || td !== 11) $display("FAIL refresh_latency%0d: got busy@%0d done@%0d, want 1 and 11", i, tb, td);
      else passed++;
    end
  endtask

  task automatic test_idle;
    exp_t e;
    int tb, td, nbusy;
    e.sel = 2'd1; e.bin = 16'd0; e.en = 4'd0; e.neg = 4'd0; e.mask = 16'd0;
    src_req = 4'b0000;
    exp_q.push_back(e);
    wait_pub(tb, td);
    e = exp_q.pop_front();
    total++;
    if ({sel, en, neg} !== {e.sel, e.en, e.neg})
      $display("FAIL idle_blank: got sel=%0d en=%b neg=%b, want sel=%0d en=%b neg=%b", sel, en, neg, e.sel, e.en, e.neg);
    else passed++;
    nbusy = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (busy !== 1'b0) nbusy++;
    end
    total++;
    if (nbusy !== 0 || en !== 4'd0) $display("FAIL idle_hold: got busy cycles=%0d en=%b, want 0 and 0000", nbusy, en);
    else passed++;
    src_req = 4'b0010;
    exp_q.push_back(model(2'd1, 8'hF9));
    wait_pub(tb, td);
    e = exp_q.pop_front();
    total++;
    if ({sel, en, neg} !== {e.sel, e.en, e.neg} || ((bin ^ e.bin) & e.mask) !== 16'h0)
      $display("FAIL idle_wake: got sel=%0d en=%b neg=%b bin=%h, want sel=%0d en=%b neg=%b bin=%h", sel, en, neg, bin, e.sel, e.en, e.neg, e.bin);
    else passed++;
    total++;
    if (tb !== 1 || td !== 11) $display("FAIL idle_wake_latency: got busy@%0d done@%0d, want 1 and 11", tb, td);
    else passed++;
  endtask

  task automatic test_reset_mid_conv;
    exp_t e;
    int tb, td, nbusy;
    btn = 1'b0;
    tick(1);
    btn = 1'b1;
    tick(4);
    total++;
    if (busy !== 1'b1 || en !== 4'b0011) $display("FAIL midconv_pre: got busy=%b en=%b, want 1 and 0011", busy, en);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({sel, bin, neg, en, busy} !== 27'd0)
      $display("FAIL midconv_reset: got sel=%0d bin=%h neg=%b en=%b busy=%b, want all 0", sel, bin, neg, en, busy);
    else passed++;
    src_req = 4'b0000;
    tick(2);
    rst_n = 1'b1;
    nbusy = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (busy !== 1'b0) nbusy++;
    end
    total++;
    if (nbusy !== 0 || en !== 4'd0 || sel !== 2'd0)
      $display("FAIL midconv_idle: got busy cycles=%0d en=%b sel=%0d, want 0, 0000, 0", nbusy, en, sel);
    else passed++;
    src_data[7:0] = 8'h05;
    src_req = 4'b0001;
    exp_q.push_back(model(2'd0, 8'h05));
    wait_pub(tb, td);
    e = exp_q.pop_front();
    total++;
    if ({sel, en, neg} !== {e.sel, e.en, e.neg} || ((bin ^ e.bin) & e.mask) !== 16'h0)
      $display("FAIL midconv_recover: got sel=%0d en=%b neg=%b bin=%h, want sel=%0d en=%b neg=%b bin=%h", sel, en, neg, bin, e.sel, e.en, e.neg, e.bin);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_neg128;
    test_btn_rr;
    test_dwell;
    test_refresh;
    test_idle;
    test_reset_mid_conv;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", passed, total);
    $fatal(1);
  end

endmodule

// File: doc/disp_scheduler.md
DISP_SCHEDULER -- requirements
Module: disp_scheduler

Interface
REQ-001 Parameter DWELL, default 50000000: auto-advance dwell in clk cycles (1 s at 50 MHz); legal range 2..2^26-1.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 src_data  input  32  four signed 8-bit sources; source i occupies bits [8i+7:8i].
REQ-005 src_req  input  4  request bits, one per source: source i wants display time.
REQ-006 btn  input  1  already-debounced pushbutton, active-low (pressed = 0).
REQ-007 auto_en  input  1  enables dwell-timer auto-advance.
REQ-008 sel  output  2  index of the source currently shown.
REQ-009 bin  output  16  BCD digit per display; digit k occupies bits [4k+3:4k], k=0 is rightmost.
REQ-010 neg  output  4  per-display minus-sign flag.
REQ-011 en  output  4  per-display enable; 0 = blank.
REQ-012 busy  output  1  high while a selection or conversion is in progress.

Function
REQ-013 FSM states IDLE, ARB, CONV, PUB, SHOW; CONV lasts exactly 8 cycles; ARB and PUB last 1 cycle each.
REQ-014 Trigger events, sampled only in IDLE and SHOW: (a) btn falling edge (registered 1->0); (b) dwell expiry; (c) src_req[sel] deasserted while in SHOW; (d) src_data for sel differs from the latched value while in SHOW.
REQ-015 Events a, b, c are advance triggers; event d is a refresh trigger that re-converts the same source without changing sel.
REQ-016 When advance and refresh coincide, advance wins; multiple advance events in one cycle produce exactly one advance.
REQ-017 Advance: grant the first asserted src_req at index sel+1, sel+2, sel+3, sel (mod 4, round-robin wrap); if the current source is the only requester, it is re-granted.
REQ-018 If no src_req is asserted at ARB: go to IDLE; en=0, neg=0; bin and sel hold their previous values.
REQ-019 In IDLE, any src_req assertion counts as an advance trigger.
REQ-020 ARB: latch the selected src_data and the new sel; compute magnitude |x| as 8 bits (-128 -> 128).
REQ-021 CONV: double-dabble on the 8-bit magnitude, one shift per cycle (add-3 applied to nibbles >=5 before each shift), producing 3 BCD digits.
REQ-022 PUB: write sel, bin, neg and en simultaneously, then go to SHOW.
REQ-023 Latency: with the trigger sampled at edge E, outputs change at edge E+10; busy is high from E through E+9 and is low from E+10.
REQ-024 Output format: leading zeros blanked (en=0); value 0 shows a single "0" on digit 0.
REQ-025 For negative values, neg=1 and en=1 on the display immediately left of the most significant digit; all other neg bits are 0; the bin value on that display is don't-care.
REQ-026 Dwell counter: counts only in SHOW with auto_en=1; it clears on entry to ARB and whenever auto_en=0; expiry occurs when it reaches DWELL-1.
REQ-027 Trigger events arriving while busy=1 are ignored (not queued), except that btn edge detection continues to track btn.

Reset
REQ-028 While rst_n=0, all of the following hold immediately, independent of clk: state=IDLE; sel=0, bin=0, neg=0, en=0, busy=0; dwell counter 0; latched data 0; btn history register=1.
REQ-029 A reset asserted mid-CONV aborts the conversion; after release the block resumes from IDLE with no stale outputs.

Verification
REQ-030 src_req=0001, src_data[7:0]=-128 -> 10 cycles after request: sel=0, en=1111, neg=1000, bin=0x0128.
REQ-031 src_req=1011, sel=1, btn pulsed low -> sel=3; press again -> sel=0 (wrap); en shows source value; exactly one advance per press.
REQ-032 DWELL=20, auto_en=1, src_req=0110 -> sel alternates 1,2 every 30 cycles (20 SHOW + 10 busy); a btn press coinciding with expiry -> single advance.
REQ-033 In SHOW with sel=2, change src_data[23:16] from 7 to 0 -> sel stays 2; after 10 cycles en=0001, bin[3:0]=0, neg=0000.
REQ-034 Drop src_req to 0000 during SHOW -> IDLE, en=0000; reassert src_req[1] -> sel=1 after 10 cycles.
REQ-035 Assert rst_n=0 on the 4th CONV cycle -> all outputs 0 immediately; release with src_req=0000 -> remains IDLE, busy=0.
